// File: rtl/io_code_buffer_if.sv
// Bus bundle for io_code_buffer: device push side, pop/bit-time control and status.
interface io_code_buffer_if #(
  parameter int CODE_W = 5,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              READY;
  logic              IN_VALID;
  logic [CODE_W-1:0] IN_CODE;
  logic              IN_ACCEPT;
  logic              SHIFT_REQ;
  logic              BIT_EN;
  logic              SER_OUT;
  logic              DIGIT_BUSY;
  logic              CTRL_VALID;
  logic [2:0]        CTRL_OUT;
  logic              OS;
  logic [CNT_W-1:0]  COUNT;
  logic              EMPTY;
  logic              OVERRUN;

  modport master (
    output READY, IN_VALID, IN_CODE, SHIFT_REQ, BIT_EN,
    input  IN_ACCEPT, SER_OUT, DIGIT_BUSY, CTRL_VALID, CTRL_OUT, OS, COUNT, EMPTY, OVERRUN
  );

  modport slave (
    input  READY, IN_VALID, IN_CODE, SHIFT_REQ, BIT_EN,
    output IN_ACCEPT, SER_OUT, DIGIT_BUSY, CTRL_VALID, CTRL_OUT, OS, COUNT, EMPTY, OVERRUN
  );
endinterface

// File: rtl/io_code_buffer.sv
// DEPTH-entry device code buffer: digits serialised LSB-first, control codes pulsed and tracked in OS.
// Optional odd-parity bit after each digit when IO_PARITY_EN is defined.
module io_code_buffer #(
  parameter int CODE_W  = 5,
  parameter int DIGIT_W = 4,
  parameter int DEPTH   = 4
) (
  input logic           CLOCK,
  input logic           rst,
  io_code_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef IO_PARITY_EN
  localparam int NBITS = DIGIT_W + 1;
`else
  localparam int NBITS = DIGIT_W;
`endif
  localparam int BC_W = $clog2(NBITS);
  localparam logic [2:0] CLS_SIGN = 3'd1;
  localparam logic [2:0] CLS_CR   = 3'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, CTRL = 2'd2} state_t;

  function automatic logic [2:0] classify(input logic [2:0] b);
    case (b)
      3'b001:  return 3'd1;
      3'b010:  return 3'd2;
      3'b011:  return 3'd3;
      3'b100:  return 3'd4;
      3'b111:  return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

`ifdef IO_PARITY_EN
  function automatic logic odd_parity(input logic [DIGIT_W-1:0] v);
    return ~^v;
  endfunction
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  logic [CODE_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r, count_nxt_s;
  logic              empty_r, accept_r, overrun_r;
  state_t            state_r, state_nxt_s;
  logic [NBITS-1:0]  shift_r, load_s;
  logic [BC_W-1:0]   bit_cnt_r;
  logic              busy_r, ctrl_valid_r, os_r;
  logic [2:0]        ctrl_out_r, cls_s;
  logic              abort_s, push_s, pop_s, is_digit_s, last_bit_s;
  logic [CODE_W-1:0] head_s;

  assign abort_s    = rst | bus.READY;
  assign head_s     = mem_r[rd_ptr_r];
  assign is_digit_s = head_s[CODE_W-1];
  assign cls_s      = classify(head_s[2:0]);
  // A full buffer stays full for the push even if an entry pops this cycle.
  assign push_s     = bus.IN_VALID & (count_r < CNT_W'(DEPTH));
  assign pop_s      = (state_r == IDLE) & bus.SHIFT_REQ & ~empty_r;
  assign last_bit_s = bus.BIT_EN & (bit_cnt_r == BC_W'(NBITS - 1));
`ifdef IO_PARITY_EN
  assign load_s = {odd_parity(head_s[DIGIT_W-1:0]), head_s[DIGIT_W-1:0]};
`else
  assign load_s = head_s[DIGIT_W-1:0];
`endif

  // Next-state decode for the IDLE/SHIFT/CTRL sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (pop_s) state_nxt_s = is_digit_s ? SHIFT : CTRL;
        else       state_nxt_s = IDLE;
      end
      SHIFT: begin
        if (last_bit_s) state_nxt_s = IDLE;
        else            state_nxt_s = SHIFT;
      end
      CTRL:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt_s = count_r;
    if (push_s && !pop_s)      count_nxt_s = count_r + CNT_W'(1);
    else if (!push_s && pop_s) count_nxt_s = count_r - CNT_W'(1);
    else                       count_nxt_s = count_r;
  end

  // Sequencer state register.
  always_ff @(posedge CLOCK) begin
    if (abort_s) state_r <= IDLE;
    else         state_r <= state_nxt_s;
  end

  // Buffer storage; contents need no reset since pointers gate every read.
  always_ff @(posedge CLOCK) begin
    if (push_s && !abort_s) mem_r[wr_ptr_r] <= bus.IN_CODE;
  end

  // Pointers, occupancy and sticky overrun.
  always_ff @(posedge CLOCK) begin
    if (abort_s) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      empty_r   <= 1'b1;
      accept_r  <= 1'b1;
      overrun_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      count_r  <= count_nxt_s;
      empty_r  <= (count_nxt_s == CNT_W'(0));
      accept_r <= (count_nxt_s < CNT_W'(DEPTH));
      if (bus.IN_VALID && !push_s) overrun_r <= 1'b1;
    end
  end

  // Digit shifter: loads at the pop edge, clears after the final bit-time.
  always_ff @(posedge CLOCK) begin
    if (abort_s) begin
      shift_r   <= '0;
      bit_cnt_r <= '0;
      busy_r    <= 1'b0;
    end else if (pop_s && is_digit_s) begin
      shift_r   <= load_s;
      bit_cnt_r <= '0;
      busy_r    <= 1'b1;
    end else if (state_r == SHIFT && bus.BIT_EN) begin
      if (last_bit_s) begin
        shift_r   <= '0;
        bit_cnt_r <= '0;
        busy_r    <= 1'b0;
      end else begin
        shift_r   <= shift_r >> 1;
        bit_cnt_r <= bit_cnt_r + BC_W'(1);
      end
    end
  end

  // Control pulse, class hold and word sign.
  always_ff @(posedge CLOCK) begin
    if (abort_s) begin
      ctrl_valid_r <= 1'b0;
      ctrl_out_r   <= 3'd0;
      os_r         <= 1'b0;
    end else begin
      ctrl_valid_r <= pop_s & ~is_digit_s;
      if (pop_s && !is_digit_s) begin
        ctrl_out_r <= cls_s;
        if (cls_s == CLS_SIGN)    os_r <= 1'b1;
        else if (cls_s == CLS_CR) os_r <= 1'b0;
      end
    end
  end

  assign bus.IN_ACCEPT  = accept_r;
  assign bus.SER_OUT    = shift_r[0];
  assign bus.DIGIT_BUSY = busy_r;
  assign bus.CTRL_VALID = ctrl_valid_r;
  assign bus.CTRL_OUT   = ctrl_out_r;
  assign bus.OS         = os_r;
  assign bus.COUNT      = count_r;
  assign bus.EMPTY      = empty_r;
  assign bus.OVERRUN    = overrun_r;
endmodule

// File: tb/tb_io_code_buffer.sv
// Directed plus randomized bench for io_code_buffer against a queue-based reference model.
module tb_io_code_buffer;
  localparam int CODE_W  = 5;
  localparam int DIGIT_W = 4;
  localparam int DEPTH   = 4;
`ifdef IO_PARITY_EN
  localparam int NB = DIGIT_W + 1;
`else
  localparam int NB = DIGIT_W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_code_buffer_if #(.CODE_W(CODE_W), .DEPTH(DEPTH)) bus ();
  io_code_buffer #(.CODE_W(CODE_W), .DIGIT_W(DIGIT_W), .DEPTH(DEPTH)) dut (
    .CLOCK(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  logic [CODE_W-1:0] q[$];
  logic m_os = 1'b0;
  logic m_ovr = 1'b0;
  int cls_tab [8] = '{0, 1, 2, 3, 4, 0, 0, 5};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".count"}, 32'(bus.COUNT), 32'(q.size()));
    chk({tag, ".empty"}, 32'(bus.EMPTY), 32'(q.size() == 0));
    chk({tag, ".accept"}, 32'(bus.IN_ACCEPT), 32'(q.size() < DEPTH));
    chk({tag, ".overrun"}, 32'(bus.OVERRUN), 32'(m_ovr));
  endtask

  task automatic do_reset(input bit use_ready);
    if (use_ready) bus.READY = 1'b1; else rst = 1'b1;
    step();
    bus.READY = 1'b0;
    rst = 1'b0;
    q.delete();
    m_os = 1'b0;
    m_ovr = 1'b0;
  endtask

  function automatic logic exp_bit(input logic [CODE_W-1:0] c, input int i);
    int v;
    v = int'(c[DIGIT_W-1:0]);
    if (i < DIGIT_W) return logic'((v >> i) & 1);
    return logic'(($countones(v) % 2) == 0);
  endfunction

  task automatic model_push(input logic [CODE_W-1:0] c);
    if (q.size() < DEPTH) q.push_back(c); else m_ovr = 1'b1;
  endtask

  task automatic push(input logic [CODE_W-1:0] c);
    bus.IN_VALID = 1'b1;
    bus.IN_CODE  = c;
    step();
    bus.IN_VALID = 1'b0;
    model_push(c);
    chk_status("push");
  endtask

  // Checks everything after the pop edge of code c (already removed from the model).
  task automatic finish_pop(input logic [CODE_W-1:0] c);
    int cls;
    chk("pop.count", 32'(bus.COUNT), 32'(q.size()));
    if (c[CODE_W-1]) begin
      chk("dig.busy0", 32'(bus.DIGIT_BUSY), 32'd1);
      chk("dig.ser0", 32'(bus.SER_OUT), 32'(exp_bit(c, 0)));
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          step();
          chk("dig.hold", 32'(bus.SER_OUT), 32'(exp_bit(c, i)));
        end
        bus.BIT_EN = 1'b1;
        step();
        bus.BIT_EN = 1'b0;
        if (i < NB - 1) begin
          chk("dig.ser", 32'(bus.SER_OUT), 32'(exp_bit(c, i + 1)));
          chk("dig.busy", 32'(bus.DIGIT_BUSY), 32'd1);
        end else begin
          chk("dig.ser_end", 32'(bus.SER_OUT), 32'd0);
          chk("dig.busy_end", 32'(bus.DIGIT_BUSY), 32'd0);
        end
        chk("dig.count", 32'(bus.COUNT), 32'(q.size()));
      end
    end else begin
      cls = cls_tab[c[2:0]];
      if (cls == 1) m_os = 1'b1;
      if (cls == 2) m_os = 1'b0;
      chk("ctl.valid", 32'(bus.CTRL_VALID), 32'd1);
      chk("ctl.class", 32'(bus.CTRL_OUT), 32'(cls));
      step();
      chk("ctl.valid_end", 32'(bus.CTRL_VALID), 32'd0);
      chk("ctl.class_hold", 32'(bus.CTRL_OUT), 32'(cls));
      chk("ctl.os", 32'(bus.OS), 32'(m_os));
    end
  endtask

  task automatic pop(input bit with_push, input logic [CODE_W-1:0] pc);
    logic [CODE_W-1:0] c;
    bus.SHIFT_REQ = 1'b1;
    bus.IN_VALID  = with_push;
    bus.IN_CODE   = pc;
    step();
    bus.SHIFT_REQ = 1'b0;
    bus.IN_VALID  = 1'b0;
    if (with_push) model_push(pc);
    c = q.pop_front();
    chk("pop.overrun", 32'(bus.OVERRUN), 32'(m_ovr));
    finish_pop(c);
  endtask

  initial begin
    logic [CODE_W-1:0] a;
    bus.READY = 1'b0; bus.IN_VALID = 1'b0; bus.IN_CODE = '0;
    bus.SHIFT_REQ = 1'b0; bus.BIT_EN = 1'b0;
    #2;
    step();
    do_reset(1'b0);
    chk_status("reset");
    chk("reset.ser", 32'(bus.SER_OUT), 32'd0);
    chk("reset.busy", 32'(bus.DIGIT_BUSY), 32'd0);
    chk("reset.cvalid", 32'(bus.CTRL_VALID), 32'd0);
    chk("reset.cout", 32'(bus.CTRL_OUT), 32'd0);
    chk("reset.os", 32'(bus.OS), 32'd0);

    // Basic digit / SIGN / CR sequence
    push(5'h13); push(5'h01); push(5'h02);
    pop(1'b0, '0); pop(1'b0, '0); pop(1'b0, '0);

    // Overfill: fifth code dropped
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) push(5'($urandom_range(0, 31)));
    chk("full.count", 32'(bus.COUNT), 32'd4);
    for (int i = 0; i < 4; i++) pop(1'b0, '0);
    chk_status("drained");

    // Full buffer with simultaneous push/pop
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) push(5'($urandom_range(0, 31)));
    pop(1'b1, 5'h1E);
    chk_status("full_pp");
    while (q.size() > 0) pop(1'b0, '0);

    // Steady-state push/pop across pointer wrap
    do_reset(1'b0);
    push(5'h11); push(5'h03);
    for (int i = 0; i < 8; i++) pop(1'b1, 5'($urandom_range(0, 31)));
    chk_status("wrap");
    while (q.size() > 0) pop(1'b0, '0);

    // READY abort mid-shift with OS set
    do_reset(1'b0);
    push(5'h01); pop(1'b0, '0);
    push(5'h1F); push(5'h05);
    bus.SHIFT_REQ = 1'b1; step(); bus.SHIFT_REQ = 1'b0;
    for (int i = 0; i < 2; i++) begin bus.BIT_EN = 1'b1; step(); end
    bus.BIT_EN = 1'b0;
    do_reset(1'b1);
    chk("abort.ser", 32'(bus.SER_OUT), 32'd0);
    chk("abort.busy", 32'(bus.DIGIT_BUSY), 32'd0);
    chk("abort.os", 32'(bus.OS), 32'd0);
    chk_status("abort");

    // SHIFT_REQ held through a digit shift
    a = 5'h10 | 5'($urandom_range(0, 15));
    push(a); push(5'($urandom_range(0, 31)));
    bus.SHIFT_REQ = 1'b1;
    step();
    void'(q.pop_front());
    finish_pop(a);
    step();
    bus.SHIFT_REQ = 1'b0;
    a = q.pop_front();
    finish_pop(a);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0: push(5'($urandom_range(0, 31)));
        1: if (q.size() > 0) pop(1'b0, '0); else push(5'($urandom_range(0, 31)));
        2: if (q.size() > 0) pop(1'b1, 5'($urandom_range(0, 31))); else push(5'($urandom_range(0, 31)));
        default: begin
          bus.SHIFT_REQ = (q.size() == 0);
          step();
          bus.SHIFT_REQ = 1'b0;
          chk_status("idle");
          chk("idle.os", 32'(bus.OS), 32'(m_os));
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/io_code_buffer.md
Name: io_code_buffer

Overview:
- Parametrised successor to the single-character OA/OB/OS I/O register path.
- Accepts device character codes (tape, typewriter, card, mag) into a DEPTH-entry buffer instead of a single OB register.
- Classifies each popped code as a digit or a control code.
- Digits are serialised LSB-first onto the line path, one bit per bit-time. Control codes raise a one-cycle class pulse and maintain the word sign OS.

Parameters:
- CODE_W, 5: device code width; MSB = digit flag (the OB5 role). Must be >= DIGIT_W+1.
- DIGIT_W, 4: digit payload width, code[DIGIT_W-1:0].
- DEPTH, 4: buffer entries; must be >= 2.

Ports:
- CLOCK  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- READY  in  1  synchronous abort: same effect as rst, one cycle.
- IN_VALID  in  1  device presents a code this cycle.
- IN_CODE  in  CODE_W  device code.
- IN_ACCEPT  out  1  high when count < DEPTH.
- SHIFT_REQ  in  1  request to pop the next entry (the CIR_M role).
- BIT_EN  in  1  one bit-time strobe.
- SER_OUT  out  1  serial digit bit.
- DIGIT_BUSY  out  1  digit shift in progress.
- CTRL_VALID  out  1  one-cycle control-code pulse.
- CTRL_OUT  out  3  control class: 0 NULL, 1 SIGN, 2 CR, 3 TAB, 4 STOP, 5 WAIT.
- OS  out  1  I/O word sign: 0 = +, 1 = -.
- COUNT  out  $clog2(DEPTH+1)  entries held.
- EMPTY  out  1  COUNT == 0.
- OVERRUN  out  1  sticky: push attempted while full.

Behaviour:
- Reset (rst or READY) values:
  - COUNT = 0, EMPTY = 1, IN_ACCEPT = 1.
  - SER_OUT = 0, DIGIT_BUSY = 0, CTRL_VALID = 0, CTRL_OUT = 0, OS = 0, OVERRUN = 0.
  - State = IDLE; buffer pointers zeroed.
  - Any in-flight digit is aborted.
- rst and READY take priority over every other event in the same cycle.
- Push:
  - Occurs when IN_VALID & (COUNT < DEPTH).
  - IN_VALID while COUNT == DEPTH drops the code and sets OVERRUN; COUNT is unchanged.
  - Simultaneous push and pop: both occur, COUNT unchanged. When full, a same-cycle pop does NOT free space for the push: it is still an overrun.
  - Pointers wrap modulo DEPTH.
- Pop:
  - Occurs only when state == IDLE & SHIFT_REQ & ~EMPTY.
  - SHIFT_REQ while EMPTY or not IDLE is ignored.
  - FIFO order is strict.
- Classification of popped code c:
  - c[CODE_W-1] = 1: DIGIT, value c[DIGIT_W-1:0].
  - Otherwise, with b0 = c[0], b1 = c[1], b2 = c[2]:
    - b2b1b0 = 001 -> SIGN
    - 010 -> CR
    - 011 -> TAB
    - 100 -> STOP
    - 111 -> WAIT
    - 000, 101, 110 -> NULL
  - Bits above c[2] in control codes are ignored.
- State machine: IDLE, SHIFT, CTRL.
  - IDLE -> SHIFT on a digit pop. The shift register loads at the pop edge. From cycle N+1: DIGIT_BUSY = 1 and SER_OUT = value bit 0.
  - In SHIFT, each BIT_EN shifts right by one. After the DIGIT_W-th BIT_EN, the state returns to IDLE the next cycle with DIGIT_BUSY = 0 and SER_OUT = 0. Cycles without BIT_EN hold all state.
  - IDLE -> CTRL on a control pop. In cycle N+1: CTRL_VALID = 1 with CTRL_OUT = class. Next cycle: IDLE, CTRL_VALID = 0; CTRL_OUT holds its last value.
- OS:
  - Set in the CTRL cycle for SIGN.
  - Cleared in the CTRL cycle for CR.
  - Unchanged for all other classes.
- A pop is possible in the same cycle the state returns to IDLE (back-to-back throughput of one pop per IDLE cycle).

Optional Feature:
- Macro IO_PARITY_EN.
- Defined:
  - After the DIGIT_W data bits, one extra bit-time shifts out an odd-parity bit over the data, so the digit occupies DIGIT_W+1 BIT_EN strobes.
  - DIGIT_BUSY stays high through the parity bit.
- Undefined: exactly DIGIT_W bit-times; no parity logic is present.

Test Plan:
- Reset, then push codes 0x13, 0x01, 0x02 -> COUNT = 3, IN_ACCEPT = 1. Pop 0x13 -> SER_OUT sequence 1,1,0,0 over 4 BIT_EN. Pop 0x01 -> CTRL_VALID = 1, CTRL_OUT = 1, OS = 1. Pop 0x02 -> CTRL_OUT = 2, OS = 0.
- DEPTH = 4: push 5 codes with no pops -> COUNT = 4, IN_ACCEPT = 0, OVERRUN = 1; 5th code never appears on pop.
- Full buffer plus simultaneous push/pop -> popped entry correct, pushed code dropped, OVERRUN = 1. With COUNT = 2, simultaneous push/pop -> COUNT stays 2 and FIFO order is preserved across pointer wrap (8 pushes/pops total).
- Digit 0x1F mid-shift (2 BIT_EN done), READY pulse -> next cycle SER_OUT = 0, DIGIT_BUSY = 0, COUNT = 0, OS = 0.
- SHIFT_REQ held high during SHIFT with 2 entries queued -> no pop until IDLE; second pop lands on the first IDLE cycle.
- With IO_PARITY_EN, digit 0x17 (value 7) -> SER_OUT 1,1,1,0,0 (parity 0) over 5 BIT_EN; digit 0x13 (value 3) -> parity bit 1.
